// File: rtl/alu_arbiter_if.sv
// Bundle between two requesters, the round-robin ALU arbiter and an external ALU.
// slave = arbiter view, master = requester/ALU view.
interface alu_arbiter_if;
    logic       req0, req1;
    logic [4:0] op0, op1;
    logic [7:0] a0, b0, a1, b1;
    logic       ack0, ack1;
    logic [7:0] result;
    logic       carry, err, busy;
    logic [7:0] alu_a1, alu_a2;
    logic [4:0] alu_control;
    logic       alu_enable;
    logic [7:0] alu_o;
    logic [2:0] alu_status;

    modport slave (
        input  req0, req1, op0, op1, a0, b0, a1, b1, alu_o, alu_status,
        output ack0, ack1, result, carry, err, busy,
               alu_a1, alu_a2, alu_control, alu_enable
    );

    modport master (
        output req0, req1, op0, op1, a0, b0, a1, b1, alu_o, alu_status,
        input  ack0, ack1, result, carry, err, busy,
               alu_a1, alu_a2, alu_control, alu_enable
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter sharing one external ALU; strobes the ALU
// for HOLD_CYCLES cycles and returns the captured result with a one-cycle ack.
module alu_arbiter #(
    parameter int HOLD_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_STROBE, S_DONE} state_t;

    localparam logic [4:0] LAST_LEGAL_OP = 5'h10;
    localparam logic [3:0] HOLD_LAST     = 4'(HOLD_CYCLES - 1);

    state_t     r_state, w_next;
    logic       r_last, r_gnt;
    logic [3:0] r_hold_cnt;
    logic       r_ack0, r_ack1, r_carry, r_err, r_enable;
    logic [7:0] r_result, r_a1, r_a2;
    logic [4:0] r_ctl;

    logic       w_any_req, w_gnt_idx, w_illegal, w_hold_done;
    logic       w_busy, w_grant, w_finish;
    logic [4:0] w_op;
    logic [7:0] w_a, w_b;
    logic       w_unused_status;

    assign w_unused_status = ^bus.alu_status[2:1];

    // On a tie the requester that did not win last time is chosen.
    assign w_any_req   = bus.req0 | bus.req1;
    assign w_gnt_idx   = (bus.req0 && bus.req1) ? ~r_last : bus.req1;
    assign w_op        = w_gnt_idx ? bus.op1 : bus.op0;
    assign w_a         = w_gnt_idx ? bus.a1  : bus.a0;
    assign w_b         = w_gnt_idx ? bus.b1  : bus.b0;
    assign w_illegal   = w_op > LAST_LEGAL_OP;
    assign w_hold_done = r_hold_cnt == HOLD_LAST;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: combinational blocks assign a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_any_req) w_next = w_illegal ? S_DONE : S_SETUP;
            S_SETUP:  w_next = S_STROBE;
            S_STROBE: if (w_hold_done) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = r_state != S_IDLE;
        w_grant  = (r_state == S_IDLE) && w_any_req;
        w_finish = (r_state == S_STROBE) && w_hold_done;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last     <= 1'b1;
            r_gnt      <= 1'b0;
            r_hold_cnt <= 4'd0;
            r_ack0     <= 1'b0;
            r_ack1     <= 1'b0;
            r_carry    <= 1'b0;
            r_err      <= 1'b0;
            r_enable   <= 1'b0;
            r_result   <= 8'h00;
            r_a1       <= 8'h00;
            r_a2       <= 8'h00;
            r_ctl      <= 5'h00;
        end else begin
            r_ack0 <= 1'b0;
            r_ack1 <= 1'b0;
            if (w_grant) begin
                r_ctl  <= w_op;
                r_a1   <= w_a;
                r_a2   <= w_b;
                r_gnt  <= w_gnt_idx;
                r_last <= w_gnt_idx;
                // Illegal codes never touch the ALU and complete on the next cycle.
                if (w_illegal) begin
                    r_result <= 8'h00;
                    r_carry  <= 1'b0;
                    r_err    <= 1'b1;
                    r_ack0   <= ~w_gnt_idx;
                    r_ack1   <= w_gnt_idx;
                end
            end
            if (r_state == S_SETUP) begin
                r_enable   <= 1'b1;
                r_hold_cnt <= 4'd0;
            end
            if (w_finish) begin
                r_enable   <= 1'b0;
                r_result   <= bus.alu_o;
                r_carry    <= bus.alu_status[0];
                r_err      <= 1'b0;
                r_ack0     <= ~r_gnt;
                r_ack1     <= r_gnt;
                r_hold_cnt <= 4'd0;
            end else if (r_state == S_STROBE) begin
                r_hold_cnt <= r_hold_cnt + 4'd1;
            end
        end
    end

    assign bus.ack0        = r_ack0;
    assign bus.ack1        = r_ack1;
    assign bus.result      = r_result;
    assign bus.carry       = r_carry;
    assign bus.err         = r_err;
    assign bus.busy        = w_busy;
    assign bus.alu_a1      = r_a1;
    assign bus.alu_a2      = r_a2;
    assign bus.alu_control = r_ctl;
    assign bus.alu_enable  = r_enable;
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: two instances (HOLD_CYCLES 1 and 4) on shared stimulus,
// a latency-based transaction model checked every cycle, plus directed literal checks.
module tb_alu_arbiter;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       req0 = 1'b0, req1 = 1'b0;
    logic [4:0] op0 = 5'h00, op1 = 5'h00;
    logic [7:0] a0 = 8'h00, b0 = 8'h00, a1 = 8'h00, b1 = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;

    alu_arbiter_if bus1 ();
    alu_arbiter_if bus4 ();

    assign bus1.req0 = req0;  assign bus4.req0 = req0;
    assign bus1.req1 = req1;  assign bus4.req1 = req1;
    assign bus1.op0  = op0;   assign bus4.op0  = op0;
    assign bus1.op1  = op1;   assign bus4.op1  = op1;
    assign bus1.a0   = a0;    assign bus4.a0   = a0;
    assign bus1.b0   = b0;    assign bus4.b0   = b0;
    assign bus1.a1   = a1;    assign bus4.a1   = a1;
    assign bus1.b1   = b1;    assign bus4.b1   = b1;

    alu_arbiter #(.HOLD_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
    alu_arbiter #(.HOLD_CYCLES(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

    // Reference ALU: {carry, result}.
    function automatic logic [8:0] alu_fn(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] r;
        case (op)
            5'h00:   r = {1'b0, a} + {1'b0, b};
            5'h01:   r = {1'b0, a} - {1'b0, b};
            5'h02:   r = {1'b0, a | b};
            5'h03:   r = {1'b0, a & b};
            5'h04:   r = {1'b0, a ^ b};
            default: r = {1'b0, a} + {1'b0, b} + {4'd0, op};
        endcase
        return r;
    endfunction

    logic [8:0] alu1_r, alu4_r;
    always @(posedge bus1.alu_enable) begin
        alu1_r = alu_fn(bus1.alu_control, bus1.alu_a1, bus1.alu_a2);
        bus1.alu_o      <= alu1_r[7:0];
        bus1.alu_status <= {2'b01, alu1_r[8]};
    end
    always @(posedge bus4.alu_enable) begin
        alu4_r = alu_fn(bus4.alu_control, bus4.alu_a1, bus4.alu_a2);
        bus4.alu_o      <= alu4_r[7:0];
        bus4.alu_status <= {2'b01, alu4_r[8]};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: m_k counts cycles since the grant edge (grant edge ends cycle 0, so
    // the first busy cycle is 1); 0 means idle. Legal ops: enable in cycles
    // 2..1+H, ack in 2+H. Illegal ops: ack in cycle 1.
    int         m_k   [2];
    logic       m_ill [2], m_gnt [2], m_last [2], m_car [2], m_err [2];
    logic [4:0] m_ctl [2];
    logic [7:0] m_a1 [2], m_a2 [2], m_res [2];
    logic [8:0] m_tmp;

    function automatic int hold_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int ack_cycle(input int d);
        return m_ill[d] ? 1 : 2 + hold_of(d);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                m_k[d] = 0;    m_ill[d] = 1'b0; m_gnt[d] = 1'b0; m_last[d] = 1'b1;
                m_car[d] = 1'b0; m_err[d] = 1'b0; m_ctl[d] = 5'h00;
                m_a1[d] = 8'h00; m_a2[d] = 8'h00; m_res[d] = 8'h00;
            end else if (m_k[d] == 0) begin
                if (req0 || req1) begin
                    m_gnt[d]  = (req0 && req1) ? !m_last[d] : req1;
                    m_last[d] = m_gnt[d];
                    m_ctl[d]  = m_gnt[d] ? op1 : op0;
                    m_a1[d]   = m_gnt[d] ? a1 : a0;
                    m_a2[d]   = m_gnt[d] ? b1 : b0;
                    m_ill[d]  = m_ctl[d] > 5'h10;
                    m_k[d]    = 1;
                    if (m_ill[d]) begin
                        m_res[d] = 8'h00; m_car[d] = 1'b0; m_err[d] = 1'b1;
                    end
                end
            end else if (m_k[d] == ack_cycle(d)) begin
                m_k[d] = 0;
            end else begin
                m_k[d]++;
                if (m_k[d] == ack_cycle(d)) begin
                    m_tmp    = alu_fn(m_ctl[d], m_a1[d], m_a2[d]);
                    m_res[d] = m_tmp[7:0];
                    m_car[d] = m_tmp[8];
                    m_err[d] = 1'b0;
                end
            end
        end
    end

    task automatic cmp(input int d, input logic busy, input logic en, input logic ack0, input logic ack1,
                       input logic [7:0] res, input logic car, input logic err,
                       input logic [7:0] x1, input logic [7:0] x2, input logic [4:0] ctl);
        logic exp_ack;
        exp_ack = (m_k[d] != 0) && (m_k[d] == ack_cycle(d));
        check($sformatf("m%0d_busy", d), busy, m_k[d] != 0);
        check($sformatf("m%0d_enable", d), en, !m_ill[d] && m_k[d] >= 2 && m_k[d] <= 1 + hold_of(d));
        check($sformatf("m%0d_ack0", d), ack0, exp_ack && !m_gnt[d]);
        check($sformatf("m%0d_ack1", d), ack1, exp_ack && m_gnt[d]);
        check($sformatf("m%0d_ack_excl", d), ack0 & ack1, 1'b0);
        check($sformatf("m%0d_result", d), res, m_res[d]);
        check($sformatf("m%0d_carry", d), car, m_car[d]);
        check($sformatf("m%0d_err", d), err, m_err[d]);
        check($sformatf("m%0d_alu_a1", d), x1, m_a1[d]);
        check($sformatf("m%0d_alu_a2", d), x2, m_a2[d]);
        check($sformatf("m%0d_alu_control", d), ctl, m_ctl[d]);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            cmp(0, bus1.busy, bus1.alu_enable, bus1.ack0, bus1.ack1, bus1.result, bus1.carry, bus1.err,
                bus1.alu_a1, bus1.alu_a2, bus1.alu_control);
            cmp(1, bus4.busy, bus4.alu_enable, bus4.ack0, bus4.ack1, bus4.result, bus4.carry, bus4.err,
                bus4.alu_a1, bus4.alu_a2, bus4.alu_control);
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    typedef struct {
        logic [4:0] op;
        logic [7:0] a, b, res;
        logic       car, err;
    } vec_t;

    vec_t vecs [5];
    int   en_cnt, n_acks, got;
    int   ack_cyc [8];
    logic ack_idx [8];
    logic [7:0] ack_res [8];

    initial begin
        vecs[0] = '{op: 5'h10, a: 8'h01, b: 8'h02, res: 8'h13, car: 1'b0, err: 1'b0};
        vecs[1] = '{op: 5'h11, a: 8'h77, b: 8'h88, res: 8'h00, car: 1'b0, err: 1'b1};
        vecs[2] = '{op: 5'h04, a: 8'hA5, b: 8'h3C, res: 8'h99, car: 1'b0, err: 1'b0};
        vecs[3] = '{op: 5'h1F, a: 8'h12, b: 8'h34, res: 8'h00, car: 1'b0, err: 1'b1};
        vecs[4] = '{op: 5'h01, a: 8'h10, b: 8'h20, res: 8'hF0, car: 1'b1, err: 1'b0};

        // Reset state.
        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", bus1.busy, 1'b0);
        check("rst_enable", bus1.alu_enable, 1'b0);
        check("rst_acks", {bus1.ack0, bus1.ack1}, 2'b00);
        check("rst_result", bus1.result, 8'h00);
        check("rst_carry_err", {bus1.carry, bus1.err}, 2'b00);
        check("rst_operands", {bus1.alu_a1, bus1.alu_a2, bus1.alu_control}, 21'h0);
        check("rst_busy4", bus4.busy, 1'b0);
        idle(2);
        rst_n = 1'b1;
        idle(2);

        // Single legal add, HOLD_CYCLES = 1.
        req0 = 1'b1; op0 = 5'h00; a0 = 8'hF0; b0 = 8'h20; en_cnt = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (bus1.alu_enable) en_cnt++;
            if (c < 3) check("add_early_ack0", bus1.ack0, 1'b0);
        end
        check("add_ack0_c3", bus1.ack0, 1'b1);
        check("add_result", bus1.result, 8'h10);
        check("add_carry", bus1.carry, 1'b1);
        check("add_err", bus1.err, 1'b0);
        check("add_enable_cycles", en_cnt, 1);
        req0 = 1'b0;
        idle(8);

        // Illegal code on requester 1.
        req1 = 1'b1; op1 = 5'h15; a1 = 8'h55; b1 = 8'h66; en_cnt = 0;
        @(negedge clk);
        check("ill_ack1_c1", bus1.ack1, 1'b1);
        check("ill_ack0", bus1.ack0, 1'b0);
        check("ill_err", bus1.err, 1'b1);
        check("ill_result", bus1.result, 8'h00);
        if (bus1.alu_enable) en_cnt++;
        req1 = 1'b0;
        @(negedge clk);
        if (bus1.alu_enable) en_cnt++;
        check("ill_no_enable", en_cnt, 0);
        check("ill_idle_c2", bus1.busy, 1'b0);
        idle(4);

        // Tie after reset, then both held high: grants alternate 0,1,0,1,0.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1'b1; op0 = 5'h02; a0 = 8'h0F; b0 = 8'h3C;
        req1 = 1'b1; op1 = 5'h03; a1 = 8'h0F; b1 = 8'h3C;
        n_acks = 0;
        for (int c = 1; c <= 19; c++) begin
            @(negedge clk);
            if ((bus1.ack0 || bus1.ack1) && n_acks < 8) begin
                ack_cyc[n_acks] = c;
                ack_idx[n_acks] = bus1.ack1;
                ack_res[n_acks] = bus1.result;
                n_acks++;
            end
        end
        check("rr_ack_count", n_acks, 5);
        for (int i = 0; i < 5 && i < n_acks; i++) begin
            check($sformatf("rr_cycle_%0d", i), ack_cyc[i], 3 + 4 * i);
            check($sformatf("rr_grant_%0d", i), ack_idx[i], i % 2);
            check($sformatf("rr_result_%0d", i), ack_res[i], (i % 2 == 1) ? 8'h0C : 8'h3F);
        end
        req0 = 1'b0; req1 = 1'b0;
        idle(10);

        // Reset during the ALU strobe discards the operation.
        req0 = 1'b1; op0 = 5'h01; a0 = 8'h10; b0 = 8'h20;
        idle(2);
        check("rstmid_enable_before", bus1.alu_enable, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_enable", bus1.alu_enable, 1'b0);
        check("rstmid_busy", bus1.busy, 1'b0);
        check("rstmid_busy4", bus4.busy, 1'b0);
        req0 = 1'b0;
        #1 rst_n = 1'b1;
        got = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (bus1.ack0 || bus1.ack1) got++;
        end
        check("rstmid_no_ack", got, 0);
        req0 = 1'b1;
        idle(3);
        check("rstmid_next_ack0", bus1.ack0, 1'b1);
        check("rstmid_next_result", {bus1.carry, bus1.result}, 9'h1F0);
        req0 = 1'b0;
        idle(8);

        // Table of single requests on requester 1, each bounded to 10 cycles.
        for (int v = 0; v < 5; v++) begin
            req1 = 1'b1; op1 = vecs[v].op; a1 = vecs[v].a; b1 = vecs[v].b;
            got = 0;
            for (int c = 0; c < 10 && got == 0; c++) begin
                @(negedge clk);
                if (bus1.ack1) got = 1;
            end
            check($sformatf("tbl%0d_ack_seen", v), got, 1);
            check($sformatf("tbl%0d_result", v), bus1.result, vecs[v].res);
            check($sformatf("tbl%0d_carry", v), bus1.carry, vecs[v].car);
            check($sformatf("tbl%0d_err", v), bus1.err, vecs[v].err);
            req1 = 1'b0;
            idle(8);
        end

        // HOLD_CYCLES = 4, request dropped and operands changed after grant.
        req0 = 1'b1; op0 = 5'h04; a0 = 8'hA5; b0 = 8'h3C; en_cnt = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (bus4.alu_enable) en_cnt++;
            check($sformatf("h4_operands_c%0d", c), {bus4.alu_control, bus4.alu_a1, bus4.alu_a2}, {5'h04, 8'hA5, 8'h3C});
            if (c < 6) check($sformatf("h4_early_ack0_c%0d", c), bus4.ack0, 1'b0);
            if (c == 1) begin
                req0 = 1'b0; op0 = 5'h1F; a0 = 8'h00; b0 = 8'h00;
            end
        end
        check("h4_ack0_c6", bus4.ack0, 1'b1);
        check("h4_result", bus4.result, 8'h99);
        check("h4_enable_cycles", en_cnt, 4);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
